hoeraa_share_arbiter: RTL
=========================

# hoeraa_share_arbiter

Shares one HOERAA-style approximate adder datapath among R requesters. Each requester issues a valid/ready add request and chooses per-transaction between approximate mode (HOERAA function) and exact mode (full N-bit add). The block arbitrates round-robin, registers operands, computes, and returns a tagged result through a registered valid/ready response port. It sits between the client engines and the single adder resource, and it keeps saturating usage counters for the power and accuracy analysis flow.

## Interface
Parameters:
- N, 16, operand and sum width
- K, 9, width of the accurate upper sub-adder; N-K >= 2 is required
- R, 4, number of requesters, 2..8
- IDW, 2, width of the requester tag; IDW >= clog2(R)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  R  per-requester request valid
- req_ready  out  R  per-requester accept; at most one bit high per cycle
- req_x  in  R*N  operand X; requester i uses bits [i*N +: N]
- req_y  in  R*N  operand Y, same packing as req_x
- req_exact  in  R  1 selects exact add, 0 selects approximate add
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_sum  out  N  sum
- rsp_co  out  1  carry out
- rsp_id  out  IDW  index of the requester that issued the request
- rsp_exact  out  1  mode that was used
- stat_approx  out  16  count of completed approximate ops, saturates at 0xFFFF
- stat_exact  out  16  count of completed exact ops, saturates at 0xFFFF

## Operation
- Approximate function, with M = N-K:
  - cin = X[M-1] & Y[M-1]
  - {Co, S[N-1:M]} = X[N-1:M] + Y[N-1:M] + cin
  - S[M-1] = cin ? (X[M-2] & Y[M-2]) : (X[M-1] | Y[M-1])
  - S[M-2] = X[M-2] | Y[M-2]
  - S[M-3:0] = all ones
- Exact function: {Co, S} = X + Y, giving an N+1-bit result.
- Arbitration:
  - Round-robin over the requesters with req_valid high, searching upward from pointer `ptr` and wrapping at R-1 to 0.
  - `ptr` resets to 0.
  - On a handshake with requester g, `ptr` becomes (g+1) mod R.
  - `ptr` does not change without a handshake.
- Handshake:
  - req_ready[g] = grant[g] & s1_free.
  - A transfer occurs when req_valid[g] & req_ready[g] are both high.
  - A requester must hold its valid, operands and mode stable until it is accepted.
- Pipeline has two register stages:
  - S1 captures x, y, exact and id.
  - The output register captures the computed sum, co, id and exact.
- Advance rules:
  - out_free = !rsp_valid | rsp_ready.
  - S1 moves to the output register when s1_valid & out_free.
  - s1_free = !s1_valid | out_free.
- The adder is combinational between S1 and the output register. There is exactly one adder path for each mode, shared by all requesters.
- Counters:
  - One counter increments on each rsp_valid & rsp_ready, selected by rsp_exact.
  - Each counter holds at 0xFFFF once it saturates.

## Timing
- Reset (asynchronous, rst_n low):
  - s1_valid = 0, rsp_valid = 0, ptr = 0
  - rsp_sum, rsp_co, rsp_id and rsp_exact = 0
  - stat counters = 0
  - req_ready = 0 while rst_n is low
- Any transaction in flight during reset is discarded and no response is produced for it.
- Latency: a request accepted at edge t gives rsp_valid high after edge t+1. The result is visible in the cycle after that edge.
- Throughput is one operation per cycle while rsp_ready is held high.
- Backpressure:
  - With rsp_ready low and both stages full, all req_ready bits are 0.
  - rsp_* outputs hold stable until they are accepted.
- Simultaneous events: when the output is consumed, S1 advances and a new request is accepted in the same cycle, no bubble is inserted.
- Responses return in acceptance order.
- A requester with continuous valid is granted at least once every R accepted transactions.

## Test plan
- Approximate path, N=16, K=9: x=0x0040, y=0x0040, exact=0 -> sum=0x009F, co=0. The same operands with exact=1 -> sum=0x0080, co=0.
- Approximate overflow: x=0xFFFF, y=0x0001, exact=0 -> sum=0xFFFF, co=0. With exact=1 -> sum=0x0000, co=1.
- Round-robin fairness: all 4 requesters valid continuously and rsp_ready=1 -> rsp_id sequence is 0,1,2,3,0,1,… with one response per cycle after the 2-cycle fill.
- Backpressure: rsp_ready=0 for 5 cycles with requesters 1 and 2 valid:
  - Exactly 2 requests are accepted, then all req_ready are 0 and rsp_* stay stable.
  - After rsp_ready returns to 1, the responses come out in order with ids 1 then 2 and no loss or duplication.
- Reset mid-operation: deassert rst_n while both stages are full -> rsp_valid=0 and counters=0 immediately. After release, the first grant goes to the lowest valid index starting from 0.
- Counter saturation: force more than 65535 exact completions (preload acceptable in sim) -> stat_exact stays at 0xFFFF and stat_approx is unaffected.

Source files
------------

// File: rtl/hoeraa_share_arbiter.sv
// Round-robin shared HOERAA approximate / exact adder.
// Two register stages (operand capture, result) with valid/ready on both sides and saturating usage counters.
module hoeraa_share_arbiter #(
    parameter int unsigned N   = 16,
    parameter int unsigned K   = 9,
    parameter int unsigned R   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [R-1:0]     req_valid,
    output logic [R-1:0]     req_ready,
    input  logic [R*N-1:0]   req_x,
    input  logic [R*N-1:0]   req_y,
    input  logic [R-1:0]     req_exact,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_sum,
    output logic             rsp_co,
    output logic [IDW-1:0]   rsp_id,
    output logic             rsp_exact,
    output logic [15:0]      stat_approx,
    output logic [15:0]      stat_exact
);

    localparam int unsigned M  = N - K;
    localparam int unsigned KW = K + 1;
    localparam int unsigned NW = N + 1;
    localparam int unsigned PW = (R > 1) ? $clog2(R) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] arb_idx;
    logic [R-1:0]  grant;
    logic          gfound;

    logic [N-1:0]  sel_x;
    logic [N-1:0]  sel_y;
    logic          sel_exact;

    logic          s1_valid;
    logic [N-1:0]  s1_x;
    logic [N-1:0]  s1_y;
    logic          s1_exact;
    logic [PW-1:0] s1_id;

    logic          out_free;
    logic          s1_free;
    logic          s1_adv;
    logic          hs;
    logic          rsp_fire;

    logic          ap_cin;
    logic [K:0]    ap_hi;
    logic [M-1:0]  ap_lo;
    logic [N:0]    ex_sum;
    logic [N-1:0]  res_sum;
    logic          res_co;

    // Round-robin search upward from ptr, wrapping at R-1.
    always_comb begin
        grant   = '0;
        gidx    = '0;
        gfound  = 1'b0;
        arb_idx = '0;
        for (int unsigned o = 0; o < R; o++) begin
            arb_idx = PW'((32'(ptr) + o) % R);
            if (!gfound && req_valid[arb_idx]) begin
                grant[arb_idx] = 1'b1;
                gidx           = arb_idx;
                gfound         = 1'b1;
            end
        end
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_exact = 1'b0;
        for (int i = 0; i < int'(R); i++) begin
            if (grant[i]) begin
                sel_x     = req_x[i*N +: N];
                sel_y     = req_y[i*N +: N];
                sel_exact = req_exact[i];
            end
        end
    end

    assign out_free  = !rsp_valid || rsp_ready;
    assign s1_free   = !s1_valid || out_free;
    assign s1_adv    = s1_valid && out_free;
    assign req_ready = rst_n ? (grant & {R{s1_free}}) : '0;
    assign hs        = |(req_valid & req_ready);
    assign rsp_fire  = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (gidx == PW'(R - 1)) ? '0 : gidx + PW'(1);
        end
    end

    // Operand stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_exact <= 1'b0;
            s1_id    <= '0;
        end else if (s1_free) begin
            s1_valid <= hs;
            if (hs) begin
                s1_x     <= sel_x;
                s1_y     <= sel_y;
                s1_exact <= sel_exact;
                s1_id    <= gidx;
            end
        end
    end

    // Shared datapath: upper K bits accurate, lower M bits approximated.
    always_comb begin
        ap_cin       = s1_x[M-1] & s1_y[M-1];
        ap_hi        = {1'b0, s1_x[N-1:M]} + {1'b0, s1_y[N-1:M]} + KW'(ap_cin);
        ap_lo        = '1;
        ap_lo[M-1]   = ap_cin ? (s1_x[M-2] & s1_y[M-2]) : (s1_x[M-1] | s1_y[M-1]);
        ap_lo[M-2]   = s1_x[M-2] | s1_y[M-2];
        ex_sum       = NW'({1'b0, s1_x}) + NW'({1'b0, s1_y});
        res_sum      = {ap_hi[K-1:0], ap_lo};
        res_co       = ap_hi[K];
        if (s1_exact) begin
            res_sum = ex_sum[N-1:0];
            res_co  = ex_sum[N];
        end
    end

    // Result stage; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_co    <= 1'b0;
            rsp_id    <= '0;
            rsp_exact <= 1'b0;
        end else if (out_free) begin
            rsp_valid <= s1_valid;
            if (s1_adv) begin
                rsp_sum   <= res_sum;
                rsp_co    <= res_co;
                rsp_id    <= IDW'(s1_id);
                rsp_exact <= s1_exact;
            end
        end
    end

    // Saturating completion counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_approx <= '0;
            stat_exact  <= '0;
        end else if (rsp_fire) begin
            if (rsp_exact) begin
                if (stat_exact != 16'hFFFF) stat_exact <= stat_exact + 16'd1;
            end else begin
                if (stat_approx != 16'hFFFF) stat_approx <= stat_approx + 16'd1;
            end
        end
    end

endmodule
